quantization_relu: RTL and testbench

QUANTIZATION_RELU -- requirements
Module: quantization_relu

---
 rtl/quantization_relu_pkg.sv | 20 ++
 rtl/quantization_relu_if.sv | 21 ++
 rtl/quantization_relu_relu_sat.sv | 18 +
 rtl/quantization_relu.sv | 120 ++++++++++++
 tb/tb_quantization_relu.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/quantization_relu_pkg.sv
// Shared types and constants for the quantization/ReLU output stage.
package quantization_relu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      ROUND,
      SAT,
      RELU,
      DONE
   } state_t;

   localparam int QMIN     = -256;
   localparam int QMAX     = 255;
   localparam int RELU_MAX = 127;

   localparam logic [30:0] DEFAULT_Q     = 31'd2014687024;
   localparam int unsigned DEFAULT_SHIFT = 8;

endpackage

// File: rtl/quantization_relu_if.sv
// Request/result bundle between the accumulator source and the quantizer.
interface quantization_relu_if;

   logic        start;
   logic [63:0] a;
   logic [8:0]  num_quant;
   logic        quant_ok;
   logic [7:0]  num;
   logic        relu_ok;

   modport master (
      output start, a,
      input  num_quant, quant_ok, num, relu_ok
   );

   modport slave (
      input  start, a,
      output num_quant, quant_ok, num, relu_ok
   );

endinterface

// File: rtl/quantization_relu_relu_sat.sv
// Combinational ReLU: 9-bit signed in, clamped to 0..RELU_MAX out.
module relu_sat
   import quantization_relu_pkg::*;
(
   input  logic signed [8:0] din,
   output logic        [7:0] dout
);

   always_comb begin
      dout = din[7:0];
      if (din[8]) begin
         dout = '0;
      end else if (din > 9'(RELU_MAX)) begin
         dout = 8'(RELU_MAX);
      end
   end

endmodule

// File: rtl/quantization_relu.sv
// Multi-cycle requantizer: Q0.31 scale, round-half-up shift, saturate, ReLU.
module quantization_relu
   import quantization_relu_pkg::*;
#(
   parameter logic [30:0] Q     = DEFAULT_Q,
   parameter int unsigned SHIFT = DEFAULT_SHIFT
)
(
   input logic                clk,
   input logic                rst,
   quantization_relu_if.slave bus
);

   localparam logic signed [95:0] Q_EXT  = {65'd0, Q};
   localparam logic signed [95:0] RND    = 96'sd1 <<< (30 + SHIFT);
   localparam logic signed [95:0] SAT_LO = 96'(QMIN);
   localparam logic signed [95:0] SAT_HI = 96'(QMAX);

   state_t state, state_nxt;
   logic   accept;

   logic signed [63:0] a_q;
   logic signed [95:0] a_ext;
   logic signed [95:0] p_q;
   logic signed [95:0] r_q;
   logic signed [8:0]  sat_val;
   logic signed [8:0]  num_quant_q;
   logic        [7:0]  relu_out;
   logic        [7:0]  num_q;
   logic               quant_ok_q;
   logic               relu_ok_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = MULT;
            end
         end
         MULT:  state_nxt = ROUND;
         ROUND: state_nxt = SAT;
         SAT:   state_nxt = RELU;
         RELU:  state_nxt = DONE;
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = MULT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Full sign extension keeps the 64x31 product exact for every accumulator value.
   assign a_ext = {{32{a_q[63]}}, a_q};

   always_comb begin
      sat_val = r_q[8:0];
      if (r_q < SAT_LO) begin
         sat_val = 9'(QMIN);
      end else if (r_q > SAT_HI) begin
         sat_val = 9'(QMAX);
      end
   end

   relu_sat u_relu_sat (
      .din  (num_quant_q),
      .dout (relu_out)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         a_q         <= '0;
         p_q         <= '0;
         r_q         <= '0;
         num_quant_q <= '0;
         num_q       <= '0;
         quant_ok_q  <= 1'b0;
         relu_ok_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q        <= bus.a;
            quant_ok_q <= 1'b0;
            relu_ok_q  <= 1'b0;
         end
         case (state)
            MULT:  p_q <= a_ext * Q_EXT;
            ROUND: r_q <= (p_q + RND) >>> (31 + SHIFT);
            SAT: begin
               num_quant_q <= sat_val;
               quant_ok_q  <= 1'b1;
            end
            RELU: begin
               num_q     <= relu_out;
               relu_ok_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.num_quant = num_quant_q;
   assign bus.quant_ok  = quant_ok_q;
   assign bus.num       = num_q;
   assign bus.relu_ok   = relu_ok_q;

endmodule

// File: tb/tb_quantization_relu.sv
// Scoreboard bench for quantization_relu against an integer-division reference model.
module tb_quantization_relu;

   localparam longint      Q_TB     = 64'd2014687024;
   localparam int unsigned SHIFT_TB = 8;

   typedef struct {
      logic [8:0] q;
      logic [7:0] n;
      int         start_edge;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   exp_t sb[$];

   logic       prev_q, prev_r;
   logic [8:0] held_q;
   logic [7:0] held_n;

   quantization_relu_if bus ();

   quantization_relu #(
      .Q     (31'd2014687024),
      .SHIFT (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // floor((a*Q + 2^(30+S)) / 2^(31+S)) via plain integer division, then clamp.
   function automatic int ref_quant(input logic signed [63:0] av);
      logic signed [127:0] x, den, qt;
      den = 128'sd1 <<< (31 + SHIFT_TB);
      x   = av;
      x   = x * Q_TB + den / 2;
      if (x >= 0) qt = x / den;
      else        qt = -((-x + den - 1) / den);
      if (qt < -256) return -256;
      if (qt > 255)  return 255;
      return int'(qt);
   endfunction

   function automatic int ref_relu(input int qv);
      if (qv < 0)   return 0;
      if (qv > 127) return 127;
      return qv;
   endfunction

   function automatic logic signed [63:0] rand_a();
      longint v;
      case ($urandom_range(3))
         0:       v = longint'($urandom_range(4000)) - 2000;
         1:       v = longint'($urandom_range(600000)) - 300000;
         2:       v = {$urandom(), $urandom()};
         default: v = (longint'($urandom) * 256) * (($urandom_range(1) == 0) ? -1 : 1);
      endcase
      return v;
   endfunction

   task automatic push_exp(input logic signed [63:0] av);
      exp_t e;
      int   qv;
      qv           = ref_quant(av);
      e.q          = 9'(qv);
      e.n          = 8'(ref_relu(qv));
      e.start_edge = cyc + 1;
      sb.push_back(e);
   endtask

   // Drive a one-cycle start; a is scrambled afterwards to show it is sampled once.
   task automatic issue(input logic signed [63:0] av, input bit expect_result);
      bus.start = 1'b1;
      bus.a     = av;
      if (expect_result) push_exp(av);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = rand_a();
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_num_quant"}, longint'(bus.num_quant), 0);
      check({tag, "_num"},       longint'(bus.num),       0);
      check({tag, "_quant_ok"},  longint'(bus.quant_ok),  0);
      check({tag, "_relu_ok"},   longint'(bus.relu_ok),   0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (bus.quant_ok && !prev_q) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_quant_ok: got quant_ok=1 expected no pending request (cycle %0d)", cyc);
            end else begin
               check("num_quant", longint'(bus.num_quant), longint'(sb[0].q));
               check("quant_latency", longint'(cyc - sb[0].start_edge), 3);
               held_q = sb[0].q;
            end
         end else if (bus.quant_ok) begin
            check("num_quant_hold", longint'(bus.num_quant), longint'(held_q));
         end

         if (bus.relu_ok && !prev_r) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_relu_ok: got relu_ok=1 expected no pending request (cycle %0d)", cyc);
            end else begin
               check("num", longint'(bus.num), longint'(sb[0].n));
               check("relu_latency", longint'(cyc - sb[0].start_edge), 4);
               held_n = sb[0].n;
               void'(sb.pop_front());
            end
         end else if (bus.relu_ok) begin
            check("num_hold", longint'(bus.num), longint'(held_n));
         end
      end
      prev_q = bus.quant_ok;
      prev_r = bus.relu_ok;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete expected 0 timeouts got 1");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint directed[6];
      checks    = 0;
      errors    = 0;
      prev_q    = 1'b0;
      prev_r    = 1'b0;
      held_q    = '0;
      held_n    = '0;
      rst       = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      directed  = '{1000, -1000, 30000, 40000, 200000, -1000000000};

      repeat (3) @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b1;

      foreach (directed[i]) begin
         issue(directed[i], 1'b1);
         repeat ($urandom_range(7, 4)) @(negedge clk);
      end

      // start during ROUND must be ignored
      issue(1000, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 64'sd40000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         issue(rand_a(), 1'b1);
         repeat ($urandom_range(7, 4)) @(negedge clk);
      end

      // reset two cycles after start aborts the request
      issue(1000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero_outputs("midreset");
      rst = 1'b1;
      issue(0, 1'b1);
      repeat (6) @(negedge clk);

      // start held through DONE: second request accepted on DONE with a=30000
      bus.start = 1'b1;
      bus.a     = 64'sd1000;
      push_exp(64'sd1000);
      @(negedge clk);
      bus.a = 64'sd30000;
      repeat (4) @(negedge clk);
      push_exp(64'sd30000);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = rand_a();
      repeat (6) @(negedge clk);

      check("pending_results", longint'(sb.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
